// File: rtl/id_ex_skid.sv
// ID->EX pipeline register with a 2-entry skid buffer (main + skid) and valid/ready handshake.
// ready_o comes straight from state, so there is no combinational path from ready_i to ready_o.
module id_ex_skid #(
   parameter int              DW         = 32,
   parameter logic [DW-1:0]   NOP_INST   = 32'h00000013,
   parameter logic [DW-1:0]   RESET_ADDR = 32'h00000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] inst_addr_i,
   input  logic [DW-1:0] inst_i,
   input  logic [DW-1:0] op_1_i,
   input  logic [DW-1:0] op_2_i,
   input  logic [4:0]    wd_addr_i,
   input  logic          reg_wen_i,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic          flush_i,
   output logic [DW-1:0] inst_addr_o,
   output logic [DW-1:0] inst_o,
   output logic [DW-1:0] op_1_o,
   output logic [DW-1:0] op_2_o,
   output logic [4:0]    wd_addr_o,
   output logic          reg_wen_o,
   output logic          valid_o,
   input  logic          ready_i
);

   typedef struct packed {
      logic [DW-1:0] addr;
      logic [DW-1:0] inst;
      logic [DW-1:0] op_1;
      logic [DW-1:0] op_2;
      logic [4:0]    wd_addr;
      logic          reg_wen;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t in_entry;
   logic   acc;
   logic   ret;

   // Handshake: an entry moves on a rising edge only when both valid and ready are high
   // on that side; valid_o and head data stay stable until EX takes the entry.
   assign ready_o  = (state_q != FULL);
   assign valid_o  = (state_q != EMPTY);
   assign acc      = valid_i & ready_o;
   assign ret      = valid_o & ready_i;
   assign in_entry = '{addr: inst_addr_i, inst: inst_i, op_1: op_1_i, op_2: op_2_i,
                       wd_addr: wd_addr_i, reg_wen: reg_wen_i};

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         // A same-cycle retire is still taken by EX; any accept is dropped.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  main_d  = in_entry;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (acc && ret) begin
                  main_d = in_entry;
               end else if (acc) begin
                  skid_d  = in_entry;
                  state_d = FULL;
               end else if (ret) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (ret) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Bubble (NOP) whenever no valid head entry is presented.
   always_comb begin
      inst_addr_o = RESET_ADDR;
      inst_o      = NOP_INST;
      op_1_o      = '0;
      op_2_o      = '0;
      wd_addr_o   = '0;
      reg_wen_o   = 1'b0;
      if (valid_o) begin
         inst_addr_o = main_q.addr;
         inst_o      = main_q.inst;
         op_1_o      = main_q.op_1;
         op_2_o      = main_q.op_2;
         wd_addr_o   = main_q.wd_addr;
         reg_wen_o   = main_q.reg_wen;
      end
   end

endmodule
